// File: rtl/led_test_pattern_gen.sv
// LED test-pattern source: generates the per-driver serial bit stream and the
// one-hot row select for bring-up. Four modes: all-on, single LED, walking LED
// and row scan. Mode and selections take effect only at column boundaries.
module led_test_pattern_gen #(
  parameter  int NB_DRIVERS   = 30,
  parameter  int NB_LEDS      = 16,
  parameter  int BITS_PER_LED = 48,
  parameter  int NB_MUX       = 8,
  parameter  int HOLD_COLUMNS = 4,
  localparam int DW = (NB_DRIVERS   > 1) ? $clog2(NB_DRIVERS)   : 1,
  localparam int LW = (NB_LEDS      > 1) ? $clog2(NB_LEDS)      : 1,
  localparam int RW = (NB_MUX       > 1) ? $clog2(NB_MUX)       : 1,
  localparam int BW = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1,
  localparam int HW = (HOLD_COLUMNS > 1) ? $clog2(HOLD_COLUMNS) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clk_enable,
  input  logic [1:0]            mode,
  input  logic [DW-1:0]         sel_driver,
  input  logic [LW-1:0]         sel_led,
  input  logic [RW-1:0]         sel_row,
  input  logic                  bit_req,
  input  logic                  column_ready,
  output logic [NB_DRIVERS-1:0] framebuffer_dat,
  output logic [NB_MUX-1:0]     mul_sel,
  output logic                  position_sync,
  output logic [15:0]           frame_cnt,
  output logic                  overrun
);

  typedef enum logic [1:0] {M_ALL_ON = 2'd0, M_SINGLE = 2'd1, M_WALK = 2'd2, M_ROW_SCAN = 2'd3} mode_e;

  mode_e          mode_q,   mode_d;
  logic [DW-1:0]  sdrv_q,   sdrv_d;
  logic [LW-1:0]  sled_q,   sled_d;
  logic [RW-1:0]  srow_q,   srow_d;
  logic [BW-1:0]  bit_q,    bit_d;
  logic [LW-1:0]  led_q,    led_d;
  logic [RW-1:0]  row_q,    row_d;
  logic [DW-1:0]  wdrv_q,   wdrv_d;
  logic [LW-1:0]  wled_q,   wled_d;
  logic [RW-1:0]  wrow_q,   wrow_d;
  logic [HW-1:0]  hold_q,   hold_d;
  logic [15:0]    frame_q,  frame_d;
  logic           ovr_q,    ovr_d;
  logic           psync_q,  psync_d;
  // Set once the last bit of the column has been consumed; a further bit_req
  // before the next column is what counts as an overrun.
  logic           done_q,   done_d;
  logic [RW-1:0]  row_idx;

  // Next-state: column_ready takes priority over bit_req; nothing moves without clk_enable
  always_comb begin
    mode_d  = mode_q;  sdrv_d = sdrv_q;  sled_d = sled_q;  srow_d = srow_q;
    bit_d   = bit_q;   led_d  = led_q;   row_d  = row_q;
    wdrv_d  = wdrv_q;  wled_d = wled_q;  wrow_d = wrow_q;  hold_d = hold_q;
    frame_d = frame_q; ovr_d  = ovr_q;   done_d = done_q;  psync_d = 1'b0;
    if (clk_enable) begin
      if (column_ready) begin
        bit_d  = '0;
        led_d  = '0;
        done_d = 1'b0;
        mode_d = mode_e'(mode);
        sdrv_d = sel_driver;
        sled_d = sel_led;
        srow_d = sel_row;
        if ((mode_d == M_WALK || mode_d == M_ROW_SCAN) && mode_d != mode_q) begin
          // Entering a scanning mode restarts it from the origin
          wdrv_d  = '0;
          wled_d  = '0;
          wrow_d  = '0;
          hold_d  = '0;
          row_d   = '0;
          psync_d = 1'b1;
        end else if (mode_d == M_WALK) begin
          if (hold_q == HW'(HOLD_COLUMNS - 1)) begin
            hold_d = '0;
            if (wled_q == LW'(NB_LEDS - 1)) begin
              wled_d = '0;
              if (wdrv_q == DW'(NB_DRIVERS - 1)) begin
                wdrv_d = '0;
                wrow_d = (wrow_q == RW'(NB_MUX - 1)) ? '0 : wrow_q + 1'b1;
              end else begin
                wdrv_d = wdrv_q + 1'b1;
              end
            end else begin
              wled_d = wled_q + 1'b1;
            end
            psync_d = (wdrv_d == '0) && (wled_d == '0) && (wrow_d == '0);
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end else if (mode_d == M_ROW_SCAN) begin
          row_d   = (row_q == RW'(NB_MUX - 1)) ? '0 : row_q + 1'b1;
          psync_d = (row_d == '0);
        end else begin
          psync_d = 1'b1;
        end
        if (psync_d) frame_d = frame_q + 16'd1;
      end else if (bit_req) begin
        if (done_q) ovr_d = 1'b1;
        if (bit_q == BW'(BITS_PER_LED - 1)) begin
          bit_d = '0;
          if (led_q == LW'(NB_LEDS - 1)) begin
            led_d  = '0;
            done_d = 1'b1;
          end else begin
            led_d = led_q + 1'b1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q <= M_ALL_ON; sdrv_q <= '0; sled_q <= '0; srow_q <= '0;
      bit_q  <= '0; led_q  <= '0; row_q  <= '0;
      wdrv_q <= '0; wled_q <= '0; wrow_q <= '0; hold_q <= '0;
      frame_q <= '0; ovr_q <= 1'b0; psync_q <= 1'b0; done_q <= 1'b0;
    end else begin
      mode_q <= mode_d; sdrv_q <= sdrv_d; sled_q <= sled_d; srow_q <= srow_d;
      bit_q  <= bit_d;  led_q  <= led_d;  row_q  <= row_d;
      wdrv_q <= wdrv_d; wled_q <= wled_d; wrow_q <= wrow_d; hold_q <= hold_d;
      frame_q <= frame_d; ovr_q <= ovr_d; psync_q <= psync_d; done_q <= done_d;
    end
  end

  // Per-driver lit decision from the current LED position and shadow mode
  for (genvar d = 0; d < NB_DRIVERS; d++) begin : g_drv
    assign framebuffer_dat[d] =
      (mode_q == M_SINGLE) ? (sdrv_q == DW'(d) && led_q == sled_q) :
      (mode_q == M_WALK)   ? (wdrv_q == DW'(d) && led_q == wled_q) :
                             1'b1;
  end

  // One-hot row select from the row source of the active mode
  always_comb begin
    row_idx = srow_q;
    if (mode_q == M_WALK)     row_idx = wrow_q;
    if (mode_q == M_ROW_SCAN) row_idx = row_q;
    for (int r = 0; r < NB_MUX; r++) mul_sel[r] = (row_idx == RW'(r));
  end

  assign position_sync = psync_q;
  assign frame_cnt     = frame_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_led_test_pattern_gen.sv
// Directed bench for led_test_pattern_gen with hand-computed expectations.
module tb_led_test_pattern_gen;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        clk_enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [4:0]  sel_driver = '0;
  logic [3:0]  sel_led = '0;
  logic [2:0]  sel_row = '0;
  logic        bit_req = 1'b0;
  logic        column_ready = 1'b0;
  logic [29:0] framebuffer_dat;
  logic [7:0]  mul_sel;
  logic        position_sync;
  logic [15:0] frame_cnt;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;
  int exp_frame = 0;

  led_test_pattern_gen #(
    .NB_DRIVERS(30), .NB_LEDS(16), .BITS_PER_LED(48), .NB_MUX(8), .HOLD_COLUMNS(4)
  ) dut (
    .clk(clk), .nrst(nrst), .clk_enable(clk_enable), .mode(mode),
    .sel_driver(sel_driver), .sel_led(sel_led), .sel_row(sel_row),
    .bit_req(bit_req), .column_ready(column_ready),
    .framebuffer_dat(framebuffer_dat), .mul_sel(mul_sel),
    .position_sync(position_sync), .frame_cnt(frame_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bitreq(input int n);
    bit_req = 1'b1;
    repeat (n) tick();
    bit_req = 1'b0;
  endtask

  task automatic colrdy();
    column_ready = 1'b1;
    tick();
    column_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int pulses;
    logic [31:0] exp;

    // Reset values
    #12;
    chk("rst_fb", framebuffer_dat, 32'h3FFFFFFF);
    chk("rst_mul", mul_sel, 32'h01);
    chk("rst_ovr", overrun, 0);
    chk("rst_sync", position_sync, 0);
    chk("rst_frame", frame_cnt, 0);
    nrst = 1'b1;
    tick();
    clk_enable = 1'b1;

    // 1: all-on stream, overrun only on the bit_req past the column end
    bad = 0;
    bit_req = 1'b1;
    for (int i = 0; i < 768; i++) begin
      if (framebuffer_dat !== 30'h3FFFFFFF || mul_sel !== 8'h01 || overrun !== 1'b0) bad++;
      tick();
    end
    chk("allon_bad_positions", bad, 0);
    chk("allon_ovr_768", overrun, 0);
    tick();
    bit_req = 1'b0;
    chk("allon_ovr_769", overrun, 1);

    // 2: single LED drv 5 / LED 3 on row 7
    mode = 2'd1; sel_driver = 5'd5; sel_led = 4'd3; sel_row = 3'd7;
    colrdy();
    exp_frame++;
    chk("single_mul", mul_sel, 32'h80);
    chk("single_sync", position_sync, 1);
    chk("single_frame", frame_cnt, exp_frame);
    tick();
    chk("single_sync_clr", position_sync, 0);
    bad = 0;
    bit_req = 1'b1;
    for (int p = 0; p < 768; p++) begin
      exp = (p >= 144 && p < 192) ? 32'h20 : 32'h0;
      if (framebuffer_dat !== exp[29:0]) bad++;
      if (p == 143) chk("single_p143", framebuffer_dat, 32'h0);
      if (p == 144) chk("single_p144", framebuffer_dat, 32'h20);
      if (p == 191) chk("single_p191", framebuffer_dat, 32'h20);
      if (p == 192) chk("single_p192", framebuffer_dat, 32'h0);
      tick();
    end
    bit_req = 1'b0;
    chk("single_bad_positions", bad, 0);

    // Out-of-range driver lights nothing
    sel_driver = 5'd31;
    colrdy();
    exp_frame++;
    bitreq(144);
    chk("single_oor_fb", framebuffer_dat, 32'h0);

    // 3: row scan, entry at row 0 then one row per column
    mode = 2'd3;
    column_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      exp = 32'(1) << (k % 8);
      chk("scan_mul", mul_sel, exp);
      chk("scan_sync", position_sync, (k % 8) == 0);
      if ((k % 8) == 0) exp_frame++;
    end
    column_ready = 1'b0;
    chk("scan_frame", frame_cnt, exp_frame);

    // 4: walking LED, 4 columns per position
    mode = 2'd2;
    colrdy();
    exp_frame++;
    chk("walk_entry_sync", position_sync, 1);
    chk("walk_entry_fb", framebuffer_dat, 32'h1);
    chk("walk_entry_mul", mul_sel, 32'h01);
    column_ready = 1'b1;
    repeat (3) tick();
    column_ready = 1'b0;
    chk("walk_hold_fb", framebuffer_dat, 32'h1);
    colrdy();
    chk("walk_adv_led0", framebuffer_dat, 32'h0);
    bitreq(48);
    chk("walk_adv_led1", framebuffer_dat, 32'h1);
    column_ready = 1'b1;
    repeat (60) tick();
    column_ready = 1'b0;
    chk("walk_drv1_fb", framebuffer_dat, 32'h2);
    chk("walk_drv1_mul", mul_sel, 32'h01);
    pulses = 0;
    column_ready = 1'b1;
    for (int c = 64; c < 15359; c++) begin
      tick();
      if (position_sync) pulses++;
    end
    column_ready = 1'b0;
    chk("walk_no_early_sync", pulses, 0);
    chk("walk_last_mul", mul_sel, 32'h80);
    bitreq(720);
    chk("walk_last_fb", framebuffer_dat, 32'h20000000);
    colrdy();
    exp_frame++;
    chk("walk_wrap_sync", position_sync, 1);
    chk("walk_wrap_mul", mul_sel, 32'h01);
    chk("walk_wrap_fb", framebuffer_dat, 32'h1);
    chk("walk_wrap_frame", frame_cnt, exp_frame);

    // 5: column_ready beats bit_req; clk_enable low freezes state
    bitreq(50);
    chk("pri_pre_fb", framebuffer_dat, 32'h0);
    bit_req = 1'b1; column_ready = 1'b1;
    tick();
    bit_req = 1'b0; column_ready = 1'b0;
    chk("pri_fb", framebuffer_dat, 32'h1);
    chk("pri_sync", position_sync, 0);
    bitreq(47);
    chk("pri_bit47_fb", framebuffer_dat, 32'h1);
    clk_enable = 1'b0; bit_req = 1'b1; column_ready = 1'b1;
    repeat (5) tick();
    chk("ce_low_fb", framebuffer_dat, 32'h1);
    chk("ce_low_sync", position_sync, 0);
    column_ready = 1'b0; clk_enable = 1'b1;
    tick();
    bit_req = 1'b0;
    chk("ce_high_fb", framebuffer_dat, 32'h0);

    // 6: asynchronous reset mid-column in walk
    chk("pre_rst_ovr", overrun, 1);
    #1;
    nrst = 1'b0;
    #2;
    chk("arst_fb", framebuffer_dat, 32'h3FFFFFFF);
    chk("arst_mul", mul_sel, 32'h01);
    chk("arst_ovr", overrun, 0);
    chk("arst_frame", frame_cnt, 0);
    chk("arst_sync", position_sync, 0);
    nrst = 1'b1;
    tick();
    bad = 0;
    bit_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (framebuffer_dat !== 30'h3FFFFFFF) bad++;
    end
    bit_req = 1'b0;
    chk("postrst_allon", bad, 0);
    colrdy();
    chk("postrst_walk_sync", position_sync, 1);
    chk("postrst_walk_frame", frame_cnt, 1);
    chk("postrst_walk_fb", framebuffer_dat, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
